// File: rtl/lms_update_engine.sv
// lms_update_engine
//   Serial LMS weight-update engine. One shared two-stage multiply pipeline
//   walks the taps one per cycle and writes each updated weight back into the
//   on-chip bank. Supports plain LMS and the three sign-LMS variants, optional
//   leakage, round-half-up, and saturation with sticky per-tap flags.
//
// Ports
//   clk          system clock, all state on posedge
//   rst_n        synchronous active-low reset
//   start_valid  update request
//   start_ready  request accepted when high (IDLE and no clear)
//   din          tap delay line samples, captured on accept
//   error        error sample, captured on accept
//   step_size    mu, captured on accept
//   mode         0 LMS, 1 sign-error, 2 sign-data, 3 sign-sign
//   leak_shift   leakage shift, 0 disables leakage
//   clear        zero weights and flags, honoured in IDLE only
//   weights      registered weight bank
//   weights_ovr  sticky per-tap saturation flags
//   busy         high in CALC and DONE
//   done         one-cycle pulse after the last weight write
//
// State  | meaning
// -------+---------------------------------------------------------
// IDLE   | waiting for a request, clear honoured here
// CALC   | issuing taps into the multiply pipe and writing results
// DONE   | one cycle after the final write, done pulse

module lms_update_engine #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 15,
    parameter int TAPS  = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start_valid,
    output logic                        start_ready,
    input  logic [TAPS-1:0][WIDTH-1:0]  din,
    input  logic [WIDTH-1:0]            error,
    input  logic [WIDTH-1:0]            step_size,
    input  logic [1:0]                  mode,
    input  logic [3:0]                  leak_shift,
    input  logic                        clear,
    output logic [TAPS-1:0][WIDTH-1:0]  weights,
    output logic [TAPS-1:0]             weights_ovr,
    output logic                        busy,
    output logic                        done
);

    localparam int TW = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int IW = $clog2(TAPS + 1);
    localparam int WB = WIDTH + 1;
    localparam int PW = 2 * WIDTH + 1;
    localparam int SW = 3 * WIDTH + 3;

    // 1.0 at FRAC fractional bits needs one bit more than a sample word.
    localparam logic signed [WB-1:0] B_ONE = WB'(1) <<< FRAC;
    localparam logic signed [SW-1:0] RND   = SW'(1) <<< (2 * FRAC - 1);
    localparam logic signed [SW-1:0] W_MAX = (SW'(1) <<< (WIDTH - 1)) - SW'(1);
    localparam logic signed [SW-1:0] W_MIN = -(SW'(1) <<< (WIDTH - 1));

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t                         r_state;
    state_t                         w_state_nxt;

    logic [TAPS-1:0][WIDTH-1:0]     r_din;
    logic signed [WIDTH-1:0]        r_err;
    logic signed [WIDTH-1:0]        r_mu;
    logic [1:0]                     r_mode;
    logic [3:0]                     r_leak;
    logic [IW-1:0]                  r_idx;
    logic signed [PW-1:0]           r_p;
    logic [TW-1:0]                  r_p_tap;
    logic                           r_p_vld;
    logic [TAPS-1:0][WIDTH-1:0]     r_w;
    logic [TAPS-1:0]                r_ovr;

    logic                           w_accept;
    logic                           w_issue;
    logic                           w_last_wr;
    logic [TW-1:0]                  w_tap;
    logic signed [WIDTH-1:0]        w_d;
    logic signed [WIDTH-1:0]        w_a;
    logic signed [WB-1:0]           w_b;
    logic                           w_neg;
    logic                           w_zero;
    logic signed [PW-1:0]           w_prod;
    logic signed [PW-1:0]           w_p_nxt;
    logic signed [WIDTH-1:0]        w_wcur;
    logic signed [SW-1:0]           w_ext;
    logic signed [SW-1:0]           w_leaked;
    logic signed [SW-1:0]           w_off;
    logic signed [SW-1:0]           w_sum;
    logic signed [SW-1:0]           w_rnd;
    logic [WIDTH-1:0]               w_w_nxt;
    logic                           w_sat;

    assign w_accept  = start_valid && start_ready;
    assign w_issue   = (r_state == S_CALC) && (r_idx != IW'(TAPS));
    assign w_last_wr = r_p_vld && (r_p_tap == TW'(TAPS - 1));
    assign w_tap     = r_idx[TW-1:0];
    assign w_d       = r_din[w_tap];

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)  w_state_nxt = S_CALC;
            S_CALC:  if (w_last_wr) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        start_ready = rst_n && (r_state == S_IDLE) && !clear;
        busy        = (r_state != S_IDLE);
        done        = (r_state == S_DONE);
    end

    // ---------------- stage 1: operand select and multiply ----------------
    always_comb begin
        w_a    = r_err;
        w_b    = WB'(w_d);
        w_neg  = 1'b0;
        w_zero = 1'b0;
        case (r_mode)
            2'd1: begin
                w_a    = r_mu;
                w_neg  = r_err[WIDTH-1];
                w_zero = (r_err == '0);
            end
            2'd2: begin
                w_b    = WB'(r_mu);
                w_neg  = w_d[WIDTH-1];
                w_zero = (w_d == '0);
            end
            2'd3: begin
                w_a    = r_mu;
                w_b    = B_ONE;
                w_neg  = r_err[WIDTH-1] ^ w_d[WIDTH-1];
                w_zero = (r_err == '0) || (w_d == '0);
            end
            default: ;
        endcase
        w_prod = PW'(w_a) * PW'(w_b);
        // PW leaves a spare bit, so negating -2^(2W-2) cannot wrap.
        if (w_zero)     w_p_nxt = '0;
        else if (w_neg) w_p_nxt = -w_prod;
        else            w_p_nxt = w_prod;
    end

    // ---------------- stage 2: leakage, accumulate, round, saturate ----------------
    always_comb begin
        w_wcur   = r_w[r_p_tap];
        w_ext    = SW'(w_wcur) <<< (2 * FRAC);
        w_leaked = (r_leak != 4'd0) ? (w_ext - (w_ext >>> r_leak)) : w_ext;
        // LMS product carries 2*FRAC fraction bits and still needs mu;
        // sign modes already include mu, so only realign to 3*FRAC.
        if (r_mode == 2'd0) w_off = (SW'(r_p) * SW'(r_mu)) <<< 1;
        else                w_off = SW'(r_p) <<< (FRAC + 1);
        w_sum = w_leaked + w_off + RND;
        w_rnd = w_sum >>> (2 * FRAC);
        w_sat = 1'b1;
        if (w_rnd > W_MAX)      w_w_nxt = {1'b0, {(WIDTH-1){1'b1}}};
        else if (w_rnd < W_MIN) w_w_nxt = {1'b1, {(WIDTH-1){1'b0}}};
        else begin
            w_w_nxt = w_rnd[WIDTH-1:0];
            w_sat   = 1'b0;
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_p     <= '0;
            r_p_tap <= '0;
            r_p_vld <= 1'b0;
            r_w     <= '0;
            r_ovr   <= '0;
        end else begin
            if (w_accept) begin
                r_din  <= din;
                r_err  <= error;
                r_mu   <= step_size;
                r_mode <= mode;
                r_leak <= leak_shift;
                r_idx  <= '0;
            end else if (w_issue) begin
                r_idx <= r_idx + IW'(1);
            end
            r_p_vld <= w_issue;
            if (w_issue) begin
                r_p     <= w_p_nxt;
                r_p_tap <= w_tap;
            end
            if ((r_state == S_IDLE) && clear) begin
                r_w   <= '0;
                r_ovr <= '0;
            end else if (r_p_vld) begin
                r_w[r_p_tap] <= w_w_nxt;
                if (w_sat) r_ovr[r_p_tap] <= 1'b1;
            end
        end
    end

    assign weights     = r_w;
    assign weights_ovr = r_ovr;

endmodule

// File: tb/tb_lms_update_engine.sv
module tb_lms_update_engine;

    localparam int WIDTH = 16;
    localparam int FRAC  = 15;
    localparam int TAPS  = 4;

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b0;
    logic                       start_valid = 1'b0;
    logic                       start_ready;
    logic [TAPS-1:0][WIDTH-1:0] din = '0;
    logic [WIDTH-1:0]           error = '0;
    logic [WIDTH-1:0]           step_size = '0;
    logic [1:0]                 mode = '0;
    logic [3:0]                 leak_shift = '0;
    logic                       clear = 1'b0;
    logic [TAPS-1:0][WIDTH-1:0] weights;
    logic [TAPS-1:0]            weights_ovr;
    logic                       busy;
    logic                       done;

    int n_cmp = 0;
    int n_err = 0;

    // reference weight bank (integers in LSB units) and sticky flags
    int              m_w[TAPS];
    logic [TAPS-1:0] m_ovr = '0;

    lms_update_engine #(.WIDTH(WIDTH), .FRAC(FRAC), .TAPS(TAPS)) dut (
        .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
        .din(din), .error(error), .step_size(step_size), .mode(mode),
        .leak_shift(leak_shift), .clear(clear), .weights(weights),
        .weights_ovr(weights_ovr), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic longint sgn(input longint x);
        if (x > 0) return 1;
        if (x < 0) return -1;
        return 0;
    endfunction

    // Weight update from the arithmetic rules: values in real-number terms
    // scaled by 2^45 (three Q1.15 factors), leak, round half-up, clamp.
    function automatic void model_update(input logic [TAPS-1:0][WIDTH-1:0] d,
                                         input logic [WIDTH-1:0] e, input logic [WIDTH-1:0] mu,
                                         input logic [1:0] md, input logic [3:0] ls);
        longint ev, mv, dv, wext, off, r;
        ev = longint'($signed(e));
        mv = longint'($signed(mu));
        for (int i = 0; i < TAPS; i++) begin
            dv   = longint'($signed(d[i]));
            wext = longint'(m_w[i]) * 1073741824;
            if (ls != 4'd0) wext = wext - (wext >>> ls);
            case (md)
                2'd0:    off = 2 * ev * dv * mv;
                2'd1:    off = 2 * sgn(ev) * mv * dv * 32768;
                2'd2:    off = 2 * ev * mv * sgn(dv) * 32768;
                default: off = 2 * sgn(ev) * sgn(dv) * mv * 1073741824;
            endcase
            r = (wext + off + 536870912) >>> 30;
            if (r > 32767) begin
                r = 32767;
                m_ovr[i] = 1'b1;
            end else if (r < -32768) begin
                r = -32768;
                m_ovr[i] = 1'b1;
            end
            m_w[i] = int'(r);
        end
    endfunction

    function automatic logic [TAPS-1:0][WIDTH-1:0] fill(input logic [WIDTH-1:0] v);
        logic [TAPS-1:0][WIDTH-1:0] t;
        for (int i = 0; i < TAPS; i++) t[i] = v;
        return t;
    endfunction

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int i = 0; i < TAPS; i++) m_w[i] = 0;
        m_ovr = '0;
    endtask

    // Presents a request and returns just after the accept edge (T0).
    task automatic start_update(input logic [TAPS-1:0][WIDTH-1:0] d, input logic [WIDTH-1:0] e,
                                input logic [WIDTH-1:0] mu, input logic [1:0] md,
                                input logic [3:0] ls);
        int n = 0;
        din = d; error = e; step_size = mu; mode = md; leak_shift = ls;
        start_valid = 1'b1;
        #1;
        while (!start_ready && n < 20) begin
            tick();
            n++;
        end
        if (!start_ready) begin
            n_cmp++; n_err++;
            $display("FAIL start_wait: start_ready=%b required 1 within 20 cycles", start_ready);
        end
        tick();
        start_valid = 1'b0;
        model_update(d, e, mu, md, ls);
        // captured copies must be used from here on
        for (int i = 0; i < TAPS; i++) din[i] = WIDTH'($urandom);
        error = WIDTH'($urandom); step_size = WIDTH'($urandom);
        mode = 2'($urandom); leak_shift = 4'($urandom);
    endtask

    task automatic finish_update();
        int n = 0;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        if (!done) begin
            n_cmp++; n_err++;
            $display("FAIL done_wait: done=%b required 1 within 20 cycles", done);
        end
        tick();
    endtask

    task automatic run_update(input logic [TAPS-1:0][WIDTH-1:0] d, input logic [WIDTH-1:0] e,
                              input logic [WIDTH-1:0] mu, input logic [1:0] md,
                              input logic [3:0] ls);
        start_update(d, e, mu, md, ls);
        finish_update();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick(); tick();
        n_cmp++;
        if (start_ready !== 1'b0) begin
            n_err++; $display("FAIL reset_ready_low: got %b required 0", start_ready);
        end
        n_cmp++;
        if (weights !== '0 || weights_ovr !== '0) begin
            n_err++; $display("FAIL reset_bank: weights=%h ovr=%b required 0", weights, weights_ovr);
        end
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++; $display("FAIL reset_status: busy=%b done=%b required 0 0", busy, done);
        end
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (start_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_ready_high: got %b required 1", start_ready);
        end
        for (int i = 0; i < TAPS; i++) m_w[i] = 0;
        m_ovr = '0;
    endtask

    task automatic test_basic_lms();
        int busy_cnt;
        logic exp_done;
        do_clear();
        start_update(fill(16'h4000), 16'h4000, 16'h4000, 2'd0, 4'd0);
        n_cmp++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_err++; $display("FAIL basic_t0: busy=%b done=%b required 1 0", busy, done);
        end
        busy_cnt = busy ? 1 : 0;
        for (int k = 1; k <= TAPS + 2; k++) begin
            tick();
            exp_done = (k == TAPS + 1);
            n_cmp++;
            if (done !== exp_done) begin
                n_err++; $display("FAIL basic_done_k%0d: got %b required %b", k, done, exp_done);
            end
            if (busy) busy_cnt++;
            if (k >= 2 && k <= TAPS + 1) begin
                n_cmp++;
                if (weights[k-2] !== 16'h2000) begin
                    n_err++; $display("FAIL basic_progress_new_k%0d: got %h required 2000", k, weights[k-2]);
                end
                if (k - 1 < TAPS) begin
                    n_cmp++;
                    if (weights[k-1] !== 16'h0000) begin
                        n_err++; $display("FAIL basic_progress_old_k%0d: got %h required 0000", k, weights[k-1]);
                    end
                end
            end
        end
        n_cmp++;
        if (busy_cnt != TAPS + 2) begin
            n_err++; $display("FAIL basic_busy_len: got %0d required %0d", busy_cnt, TAPS + 2);
        end
        n_cmp++;
        if (start_ready !== 1'b1) begin
            n_err++; $display("FAIL basic_ready_back: got %b required 1", start_ready);
        end
        run_update(fill(16'h4000), 16'h4000, 16'h4000, 2'd0, 4'd0);
        for (int i = 0; i < TAPS; i++) begin
            n_cmp++;
            if (weights[i] !== 16'h4000) begin
                n_err++; $display("FAIL basic_second_w%0d: got %h required 4000", i, weights[i]);
            end
        end
    endtask

    task automatic test_saturation();
        do_clear();
        run_update(fill(16'h4000), 16'h0001, 16'h3800, 2'd3, 4'd0);
        n_cmp++;
        if (weights !== fill(16'h7000)) begin
            n_err++; $display("FAIL sat_preload: got %h required all 7000", weights);
        end
        run_update(fill(16'h4000), 16'h4000, 16'h4000, 2'd0, 4'd0);
        n_cmp++;
        if (weights !== fill(16'h7FFF) || weights_ovr !== 4'b1111) begin
            n_err++; $display("FAIL sat_clamp: weights=%h ovr=%b required all 7fff 1111", weights, weights_ovr);
        end
        run_update(fill(16'h4000), 16'h0000, 16'h4000, 2'd0, 4'd0);
        n_cmp++;
        if (weights !== fill(16'h7FFF) || weights_ovr !== 4'b1111) begin
            n_err++; $display("FAIL sat_sticky: weights=%h ovr=%b required all 7fff 1111", weights, weights_ovr);
        end
        do_clear();
        n_cmp++;
        if (weights !== '0 || weights_ovr !== '0) begin
            n_err++; $display("FAIL sat_clear: weights=%h ovr=%b required 0", weights, weights_ovr);
        end
    endtask

    task automatic test_sign_modes();
        do_clear();
        run_update(fill(16'h4000), 16'hFFFF, 16'h4000, 2'd1, 4'd0);
        n_cmp++;
        if (weights !== fill(16'hC000)) begin
            n_err++; $display("FAIL sign_err_mode: got %h required all c000", weights);
        end
        do_clear();
        run_update(fill(16'h4000), 16'hFFFF, 16'h4000, 2'd3, 4'd0);
        n_cmp++;
        if (weights !== fill(16'h8000) || weights_ovr !== 4'b0000) begin
            n_err++; $display("FAIL sign_sign_mode: weights=%h ovr=%b required all 8000 0000", weights, weights_ovr);
        end
        run_update(fill(16'h4000), 16'h0000, 16'h4000, 2'd1, 4'd0);
        n_cmp++;
        if (weights !== fill(16'h8000)) begin
            n_err++; $display("FAIL sign_zero_err: got %h required all 8000", weights);
        end
    endtask

    task automatic test_leakage();
        do_clear();
        run_update(fill(16'h4000), 16'h0001, 16'h2000, 2'd3, 4'd0);
        run_update(fill(16'h1234), 16'h0000, 16'h4000, 2'd0, 4'd2);
        n_cmp++;
        if (weights !== fill(16'h3000)) begin
            n_err++; $display("FAIL leak_shift2: got %h required all 3000", weights);
        end
        do_clear();
        run_update(fill(16'h4000), 16'h0001, 16'h2000, 2'd3, 4'd0);
        run_update(fill(16'h1234), 16'h0000, 16'h4000, 2'd0, 4'd0);
        n_cmp++;
        if (weights !== fill(16'h4000)) begin
            n_err++; $display("FAIL leak_off: got %h required all 4000", weights);
        end
    endtask

    task automatic test_back_to_back();
        int acc[$];
        int cyc = 0;
        int n = 0;
        logic [TAPS-1:0][WIDTH-1:0] d;
        do_clear();
        for (int i = 0; i < TAPS; i++) d[i] = WIDTH'($urandom_range(0, 16'h1FFF));
        din = d; error = 16'h0800; step_size = 16'h1000; mode = 2'd0; leak_shift = 4'd0;
        start_valid = 1'b1;
        #1;
        while (acc.size() < 3 && cyc < 60) begin
            if (start_ready) begin
                acc.push_back(cyc);
                model_update(d, 16'h0800, 16'h1000, 2'd0, 4'd0);
            end
            tick();
            cyc++;
        end
        start_valid = 1'b0;
        while (busy && n < 30) begin
            tick();
            n++;
        end
        n_cmp++;
        if (acc.size() != 3 || busy) begin
            n_err++; $display("FAIL b2b_accepts: got %0d accepts busy=%b required 3 then idle", acc.size(), busy);
        end else begin
            for (int j = 1; j < 3; j++) begin
                n_cmp++;
                if (acc[j] - acc[j-1] != TAPS + 3) begin
                    n_err++; $display("FAIL b2b_spacing%0d: got %0d required %0d", j, acc[j] - acc[j-1], TAPS + 3);
                end
            end
        end
        for (int i = 0; i < TAPS; i++) begin
            n_cmp++;
            if (weights[i] !== WIDTH'(m_w[i])) begin
                n_err++; $display("FAIL b2b_w%0d: got %h required %h", i, weights[i], WIDTH'(m_w[i]));
            end
        end
    endtask

    task automatic test_collision();
        clear = 1'b1;
        start_valid = 1'b1;
        #1;
        n_cmp++;
        if (start_ready !== 1'b0) begin
            n_err++; $display("FAIL coll_ready: got %b required 0", start_ready);
        end
        tick();
        clear = 1'b0;
        start_valid = 1'b0;
        for (int i = 0; i < TAPS; i++) m_w[i] = 0;
        m_ovr = '0;
        n_cmp++;
        if (busy !== 1'b0 || weights !== '0 || weights_ovr !== '0) begin
            n_err++; $display("FAIL coll_clear: busy=%b weights=%h ovr=%b required 0", busy, weights, weights_ovr);
        end
        start_update(fill(16'h4000), 16'h4000, 16'h4000, 2'd0, 4'd0);
        tick();
        clear = 1'b1;
        tick(); tick();
        clear = 1'b0;
        finish_update();
        n_cmp++;
        if (weights !== fill(16'h2000)) begin
            n_err++; $display("FAIL coll_clear_in_calc: got %h required all 2000", weights);
        end
    endtask

    task automatic test_reset_mid();
        int n_done = 0;
        start_update(fill(16'h4000), 16'h4000, 16'h4000, 2'd0, 4'd0);
        tick(); tick();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (start_ready !== 1'b0) begin
            n_err++; $display("FAIL rmid_ready_low: got %b required 0", start_ready);
        end
        tick();
        n_cmp++;
        if (weights !== '0 || weights_ovr !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            n_err++; $display("FAIL rmid_state: weights=%h ovr=%b busy=%b done=%b required 0",
                              weights, weights_ovr, busy, done);
        end
        rst_n = 1'b1;
        for (int i = 0; i < TAPS; i++) m_w[i] = 0;
        m_ovr = '0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (done) n_done++;
        end
        n_cmp++;
        if (n_done != 0 || busy !== 1'b0 || start_ready !== 1'b1) begin
            n_err++; $display("FAIL rmid_idle: done_pulses=%0d busy=%b ready=%b required 0 0 1",
                              n_done, busy, start_ready);
        end
        run_update(fill(16'h2000), 16'h4000, 16'h4000, 2'd0, 4'd0);
        for (int i = 0; i < TAPS; i++) begin
            n_cmp++;
            if (weights[i] !== WIDTH'(m_w[i])) begin
                n_err++; $display("FAIL rmid_new_w%0d: got %h required %h", i, weights[i], WIDTH'(m_w[i]));
            end
        end
    endtask

    task automatic test_random();
        logic [TAPS-1:0][WIDTH-1:0] d;
        logic [WIDTH-1:0] e, mu;
        logic [1:0] md;
        logic [3:0] ls;
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 7) == 0) do_clear();
            for (int i = 0; i < TAPS; i++)
                d[i] = ($urandom_range(0, 4) == 0) ? '0 : WIDTH'($urandom);
            e  = ($urandom_range(0, 4) == 0) ? '0 : WIDTH'($urandom);
            mu = ($urandom_range(0, 1) == 0) ? WIDTH'($urandom_range(0, 16'h0FFF)) : WIDTH'($urandom);
            md = 2'($urandom_range(0, 3));
            ls = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            run_update(d, e, mu, md, ls);
            for (int i = 0; i < TAPS; i++) begin
                n_cmp++;
                if (weights[i] !== WIDTH'(m_w[i])) begin
                    n_err++; $display("FAIL rand_it%0d_w%0d: got %h required %h (mode %0d leak %0d)",
                                      it, i, weights[i], WIDTH'(m_w[i]), md, ls);
                end
            end
            n_cmp++;
            if (weights_ovr !== m_ovr) begin
                n_err++; $display("FAIL rand_it%0d_ovr: got %b required %b", it, weights_ovr, m_ovr);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < TAPS; i++) m_w[i] = 0;
        test_reset();
        test_basic_lms();
        test_saturation();
        test_sign_modes();
        test_leakage();
        test_back_to_back();
        test_collision();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
